pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
Parametrised pipeline controller for the 5-stage RV32 core (IF/ID/EX/MEM/WB); replaces the single-cycle-memory hazard logic. Tracks per-stage valid bits and a redirect FSM. Generates stall, flush and bubble controls for every pipeline register, plus EX operand-forwarding selects. Handles load-use hazards, taken branch/jump redirects, and variable-latency instruction and data memories through ready handshakes.

Parameters:
REG_AW, 5, register-index width (32 architectural regs)
LOAD_USE_CYCLES, 1, load-use stall depth: 1 = load data forwardable from WB; 2 = also stall while the load is in MEM (registered dmem)
PERF_W, 32, width of performance counters (used only with PIPE_CTRL_PERF_EN)

Ports:
clk  in  1  clock
rstn  in  1  active-low async reset
i_imem_ready  in  1  fetch data valid this cycle
i_dmem_req  in  1  MEM stage issuing load/store this cycle
i_dmem_ready  in  1  data access completes this cycle
id_rs1, id_rs2  in  REG_AW  ID source regs
id_use_rs1, id_use_rs2  in  1  ID instruction reads rs1/rs2
ex_rs1, ex_rs2  in  REG_AW  EX source regs
ex_rd  in  REG_AW;  ex_reg_write, ex_is_load  in  1
mem_rd  in  REG_AW;  mem_reg_write, mem_is_load  in  1
wb_rd  in  REG_AW;  wb_reg_write  in  1
ex_redirect  in  1  EX resolved taken branch/jump
if_stall  out  1  hold PC
if_id_stall, if_id_flush  out  1  IF/ID hold / bubble
id_ex_stall, id_ex_flush  out  1  ID/EX hold / bubble
ex_mem_stall, ex_mem_flush  out  1  EX/MEM hold / bubble
mem_wb_flush  out  1  MEM/WB bubble
fwd_a_sel, fwd_b_sel  out  2  00 regfile, 01 MEM alu result, 10 WB data
stage_valid  out  4  {wb,mem,ex,id} valid bits
o_perf_stall_cyc, o_perf_flush_cnt, o_perf_retired  out  PERF_W  counters

Behaviour:
- Reset (async, rstn=0): stage_valid=0, FSM=RUN, counters=0, all stall/flush outputs 0, fwd sels 00. Outputs are combinational from registered state and inputs.
- Hazard qualification: only valid stages count; rd==0 never matches.
- Priority, highest first: DMEM_WAIT > REDIRECT > LOAD_USE > IMEM_WAIT.
- DMEM_WAIT (i_dmem_req & !i_dmem_ready & mem valid): if_stall, if_id_stall, id_ex_stall, ex_mem_stall=1; mem_wb_flush=1. A coincident ex_redirect is held in EX and acted on after completion.
- REDIRECT (ex_redirect & ex valid): if_id_flush=1 and id_ex_flush=1 in the same cycle; the EX instruction proceeds.
  - If i_imem_ready=0 that cycle, FSM goes to RWAIT and keeps if_id_flush=1 until i_imem_ready=1, dropping the stale fetch, then returns to RUN.
- LOAD_USE: ex_is_load & ex_reg_write & ex_rd matches a used id_rs (LOAD_USE_CYCLES=2: also mem_is_load & mem_rd match).
  - Response: if_stall=1, if_id_stall=1, id_ex_flush=1.
- IMEM_WAIT (RUN & !i_imem_ready): if_stall=1 and if_id_flush=1; downstream proceeds.
- Forwarding (per ex_rs, ex valid, rs!=0): MEM match with mem_reg_write & !mem_is_load -> 01; else WB match with wb_reg_write -> 10; else 00. MEM is checked before WB.
- Valid update per register: flush -> 0; stall -> hold; else upstream valid. The id bit's upstream value is i_imem_ready outside RWAIT.
- FSM: RUN <-> RWAIT only. Reset mid-operation returns to RUN with empty pipe.

Optional Feature:
PIPE_CTRL_PERF_EN:
- Defined: o_perf_stall_cyc increments on cycles with if_stall=1. o_perf_flush_cnt increments per REDIRECT event (once, not per RWAIT cycle). o_perf_retired increments when the wb valid bit is 1. All wrap modulo 2^PERF_W.
- Undefined: ports present, tied 0, no counter flops.

Decomposition:
- Shared package core_pkg: fwd_sel_e enum (FWD_RF, FWD_MEM, FWD_WB), pipe_state_e (RUN, RWAIT), stage index constants.
- One sub-module, fwd_unit: combinational forwarding select, instanced twice (operands a and b).

Test Plan:
- Load-use: ex `lw x5` valid, id `add x6,x5,x1` -> one cycle if_stall=1, id_ex_flush=1; next cycle fwd_a_sel=10.
- Back-to-back ALU: mem rd=x3 alu, wb rd=x3, ex_rs1=x3 -> fwd_a_sel=01; with ex_rs1=x0 -> 00.
- Redirect with i_imem_ready=0 for 3 cycles -> if_id_flush=1 for 4 cycles, then FSM RUN, o_perf_flush_cnt=1.
- Dmem wait 4 cycles with concurrent ex_redirect -> EX/MEM frozen 4 cycles, mem_wb_flush=1 each; redirect flush fires in cycle 5.
- LOAD_USE_CYCLES=2: load in MEM, id uses rd -> stall 1 cycle; same with LOAD_USE_CYCLES=1 -> no stall, fwd 10 next cycle.
- rstn low mid-stall -> stage_valid=0, all controls 0 immediately (async).

Source files
------------

// File: rtl/core_pkg.sv
// Shared types for the RV32 pipeline controller: forwarding selects,
// redirect FSM states and stage indices into the stage-valid vector.
package core_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    RUN   = 1'b0,
    RWAIT = 1'b1
  } pipe_state_e;

  localparam int STG_ID  = 0;
  localparam int STG_EX  = 1;
  localparam int STG_MEM = 2;
  localparam int STG_WB  = 3;

endpackage

// File: rtl/fwd_unit.sv
// EX operand forwarding select for one source register; MEM beats WB,
// loads in MEM are never forwarded (their data is not ready yet).
module fwd_unit
  import core_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              ex_vld_i,
  input  logic [REG_AW-1:0] rs_i,
  input  logic              mem_vld_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic              mem_reg_write_i,
  input  logic              mem_is_load_i,
  input  logic              wb_vld_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic              wb_reg_write_i,
  output fwd_sel_e          sel_o
);

  always_comb begin
    sel_o = FWD_RF;
    if (ex_vld_i && (rs_i != '0)) begin
      if (mem_vld_i && mem_reg_write_i && !mem_is_load_i && (mem_rd_i == rs_i)) begin
        sel_o = FWD_MEM;
      end else if (wb_vld_i && wb_reg_write_i && (wb_rd_i == rs_i)) begin
        sel_o = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// 5-stage pipeline controller: stage valids, redirect FSM, stall/flush and
// forwarding selects. Performance counters exist only with PIPE_CTRL_PERF_EN.
module pipe_ctrl
  import core_pkg::*;
#(
  parameter int REG_AW          = 5,
  parameter int LOAD_USE_CYCLES = 1,
  parameter int PERF_W          = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_imem_ready,
  input  logic              i_dmem_req,
  input  logic              i_dmem_ready,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rs1,
  input  logic [REG_AW-1:0] ex_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  input  logic              mem_is_load,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_write,
  input  logic              ex_redirect,
  output logic              if_stall,
  output logic              if_id_stall,
  output logic              if_id_flush,
  output logic              id_ex_stall,
  output logic              id_ex_flush,
  output logic              ex_mem_stall,
  output logic              ex_mem_flush,
  output logic              mem_wb_flush,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic [3:0]        stage_valid,
  output logic [PERF_W-1:0] o_perf_stall_cyc,
  output logic [PERF_W-1:0] o_perf_flush_cnt,
  output logic [PERF_W-1:0] o_perf_retired
);

  localparam bit LU_MEM = (LOAD_USE_CYCLES >= 2);

  pipe_state_e state_q, state_d;
  logic [3:0]  vld_q, vld_d;
  logic        id_v, ex_v, mem_v, wb_v;
  logic        dmem_wait, redirect, ex_lu, mem_lu, load_use;
  logic        c_if_stall, c_if_id_stall, c_if_id_flush, c_id_ex_stall;
  logic        c_id_ex_flush, c_ex_mem_stall, c_ex_mem_flush, c_mem_wb_flush;
  fwd_sel_e    fwd_a, fwd_b;

  assign id_v  = vld_q[STG_ID];
  assign ex_v  = vld_q[STG_EX];
  assign mem_v = vld_q[STG_MEM];
  assign wb_v  = vld_q[STG_WB];

  assign dmem_wait = i_dmem_req && !i_dmem_ready && mem_v;
  // A redirect seen during a data wait stays in EX and fires once MEM completes.
  assign redirect  = ex_redirect && ex_v && !dmem_wait;

  assign ex_lu  = ex_v && ex_is_load && ex_reg_write && (ex_rd != '0) && id_v &&
                  ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
  assign mem_lu = mem_v && mem_is_load && mem_reg_write && (mem_rd != '0) && id_v &&
                  ((id_use_rs1 && (id_rs1 == mem_rd)) || (id_use_rs2 && (id_rs2 == mem_rd)));
  assign load_use = ex_lu || (LU_MEM && mem_lu);

  always_comb begin
    c_if_stall     = 1'b0;
    c_if_id_stall  = 1'b0;
    c_if_id_flush  = 1'b0;
    c_id_ex_stall  = 1'b0;
    c_id_ex_flush  = 1'b0;
    c_ex_mem_stall = 1'b0;
    c_ex_mem_flush = 1'b0;
    c_mem_wb_flush = 1'b0;
    if (dmem_wait) begin
      c_if_stall     = 1'b1;
      c_if_id_stall  = (state_q != RWAIT);
      c_if_id_flush  = (state_q == RWAIT);
      c_id_ex_stall  = 1'b1;
      c_ex_mem_stall = 1'b1;
      c_mem_wb_flush = 1'b1;
    end else if (redirect) begin
      c_if_id_flush = 1'b1;
      c_id_ex_flush = 1'b1;
    end else if (load_use) begin
      c_if_stall    = 1'b1;
      c_if_id_stall = 1'b1;
      c_id_ex_flush = 1'b1;
    end else if (state_q == RWAIT) begin
      // Whatever returns while waiting is the stale wrong-path fetch.
      c_if_id_flush = 1'b1;
      c_if_stall    = !i_imem_ready;
    end else if (!i_imem_ready) begin
      c_if_stall    = 1'b1;
      c_if_id_flush = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (redirect && !i_imem_ready) state_d = RWAIT;
      RWAIT:   if (i_imem_ready) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    vld_d = vld_q;
    if (c_if_id_flush)       vld_d[STG_ID] = 1'b0;
    else if (!c_if_id_stall) vld_d[STG_ID] = (state_q == RWAIT) ? 1'b0 : i_imem_ready;
    if (c_id_ex_flush)       vld_d[STG_EX] = 1'b0;
    else if (!c_id_ex_stall) vld_d[STG_EX] = id_v;
    if (c_ex_mem_flush)       vld_d[STG_MEM] = 1'b0;
    else if (!c_ex_mem_stall) vld_d[STG_MEM] = ex_v;
    vld_d[STG_WB] = c_mem_wb_flush ? 1'b0 : mem_v;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= RUN;
      vld_q   <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
    end
  end

  // Controls are forced low while reset is held, without waiting for a clock.
  assign if_stall     = rstn && c_if_stall;
  assign if_id_stall  = rstn && c_if_id_stall;
  assign if_id_flush  = rstn && c_if_id_flush;
  assign id_ex_stall  = rstn && c_id_ex_stall;
  assign id_ex_flush  = rstn && c_id_ex_flush;
  assign ex_mem_stall = rstn && c_ex_mem_stall;
  assign ex_mem_flush = rstn && c_ex_mem_flush;
  assign mem_wb_flush = rstn && c_mem_wb_flush;
  assign stage_valid  = vld_q;

  fwd_unit #(.REG_AW(REG_AW)) u_fwd_a (
    .ex_vld_i        (ex_v),
    .rs_i            (ex_rs1),
    .mem_vld_i       (mem_v),
    .mem_rd_i        (mem_rd),
    .mem_reg_write_i (mem_reg_write),
    .mem_is_load_i   (mem_is_load),
    .wb_vld_i        (wb_v),
    .wb_rd_i         (wb_rd),
    .wb_reg_write_i  (wb_reg_write),
    .sel_o           (fwd_a)
  );

  fwd_unit #(.REG_AW(REG_AW)) u_fwd_b (
    .ex_vld_i        (ex_v),
    .rs_i            (ex_rs2),
    .mem_vld_i       (mem_v),
    .mem_rd_i        (mem_rd),
    .mem_reg_write_i (mem_reg_write),
    .mem_is_load_i   (mem_is_load),
    .wb_vld_i        (wb_v),
    .wb_rd_i         (wb_rd),
    .wb_reg_write_i  (wb_reg_write),
    .sel_o           (fwd_b)
  );

  assign fwd_a_sel = fwd_a;
  assign fwd_b_sel = fwd_b;

`ifdef PIPE_CTRL_PERF_EN
  logic [PERF_W-1:0] stall_cyc_q, flush_cnt_q, retired_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cyc_q <= '0;
      flush_cnt_q <= '0;
      retired_q   <= '0;
    end else begin
      if (c_if_stall) stall_cyc_q <= stall_cyc_q + 1'b1;
      if (redirect)   flush_cnt_q <= flush_cnt_q + 1'b1;
      if (wb_v)       retired_q   <= retired_q + 1'b1;
    end
  end

  assign o_perf_stall_cyc = stall_cyc_q;
  assign o_perf_flush_cnt = flush_cnt_q;
  assign o_perf_retired   = retired_q;
`else
  assign o_perf_stall_cyc = '0;
  assign o_perf_flush_cnt = '0;
  assign o_perf_retired   = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl; two instances differ only in load-use depth.
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       i_imem_ready, i_dmem_req, i_dmem_ready;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic       id_use_rs1, id_use_rs2, ex_reg_write, ex_is_load;
  logic       mem_reg_write, mem_is_load, wb_reg_write, ex_redirect;

  logic        a_if_stall, a_if_id_stall, a_if_id_flush, a_id_ex_stall, a_id_ex_flush;
  logic        a_ex_mem_stall, a_ex_mem_flush, a_mem_wb_flush;
  logic [1:0]  a_fwd_a, a_fwd_b;
  logic [3:0]  a_valid;
  logic [31:0] a_stall_cyc, a_flush_cnt, a_retired;

  logic        b_if_stall, b_if_id_stall, b_if_id_flush, b_id_ex_stall, b_id_ex_flush;
  logic        b_ex_mem_stall, b_ex_mem_flush, b_mem_wb_flush;
  logic [1:0]  b_fwd_a, b_fwd_b;
  logic [3:0]  b_valid;
  logic [31:0] b_stall_cyc, b_flush_cnt, b_retired;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.REG_AW(5), .LOAD_USE_CYCLES(1), .PERF_W(32)) u_lu1 (
    .clk(clk), .rstn(rstn), .i_imem_ready(i_imem_ready), .i_dmem_req(i_dmem_req),
    .i_dmem_ready(i_dmem_ready), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_is_load(mem_is_load),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .ex_redirect(ex_redirect),
    .if_stall(a_if_stall), .if_id_stall(a_if_id_stall), .if_id_flush(a_if_id_flush),
    .id_ex_stall(a_id_ex_stall), .id_ex_flush(a_id_ex_flush),
    .ex_mem_stall(a_ex_mem_stall), .ex_mem_flush(a_ex_mem_flush),
    .mem_wb_flush(a_mem_wb_flush), .fwd_a_sel(a_fwd_a), .fwd_b_sel(a_fwd_b),
    .stage_valid(a_valid), .o_perf_stall_cyc(a_stall_cyc),
    .o_perf_flush_cnt(a_flush_cnt), .o_perf_retired(a_retired)
  );

  pipe_ctrl #(.REG_AW(5), .LOAD_USE_CYCLES(2), .PERF_W(32)) u_lu2 (
    .clk(clk), .rstn(rstn), .i_imem_ready(i_imem_ready), .i_dmem_req(i_dmem_req),
    .i_dmem_ready(i_dmem_ready), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_is_load(mem_is_load),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .ex_redirect(ex_redirect),
    .if_stall(b_if_stall), .if_id_stall(b_if_id_stall), .if_id_flush(b_if_id_flush),
    .id_ex_stall(b_id_ex_stall), .id_ex_flush(b_id_ex_flush),
    .ex_mem_stall(b_ex_mem_stall), .ex_mem_flush(b_ex_mem_flush),
    .mem_wb_flush(b_mem_wb_flush), .fwd_a_sel(b_fwd_a), .fwd_b_sel(b_fwd_b),
    .stage_valid(b_valid), .o_perf_stall_cyc(b_stall_cyc),
    .o_perf_flush_cnt(b_flush_cnt), .o_perf_retired(b_retired)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_inputs();
    i_imem_ready  = 1'b1;
    i_dmem_req    = 1'b0;
    i_dmem_ready  = 1'b1;
    id_rs1 = '0; id_rs2 = '0; ex_rs1 = '0; ex_rs2 = '0;
    ex_rd = '0; mem_rd = '0; wb_rd = '0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_reg_write = 1'b0; ex_is_load = 1'b0;
    mem_reg_write = 1'b0; mem_is_load = 1'b0;
    wb_reg_write = 1'b0; ex_redirect = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Leaves the pipe full (stage_valid=1111), 2 time units after a clock edge.
  task automatic reset_fill();
    rstn = 1'b0;
    clr_inputs();
    #3;
    rstn = 1'b1;
    repeat (4) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0;
    clr_inputs();
    i_imem_ready = 1'b0;
    #1;
    chk("rst_valid",       a_valid, 4'h0);
    chk("rst_if_stall",    a_if_stall, 1'b0);
    chk("rst_if_id_flush", a_if_id_flush, 1'b0);
    chk("rst_fwd_a",       a_fwd_a, 2'b00);
    chk("rst_lu2_valid",   b_valid, 4'h0);
    chk("rst_perf_stall",  a_stall_cyc, 32'd0);

    reset_fill();
    chk("fill_valid", a_valid, 4'hF);
    chk("fill_perf_retired", a_retired, 32'd0);

    // Forwarding is combinational on the current stage contents.
    mem_rd = 5'd3; mem_reg_write = 1'b1; wb_rd = 5'd3; wb_reg_write = 1'b1;
    ex_rs1 = 5'd3; ex_rs2 = 5'd3;
    #1;
    chk("fwd_a_mem", a_fwd_a, 2'b01);
    chk("fwd_b_mem", a_fwd_b, 2'b01);
    mem_is_load = 1'b1;
    #1;
    chk("fwd_a_memload_wb", a_fwd_a, 2'b10);
    mem_is_load = 1'b0; mem_reg_write = 1'b0;
    #1;
    chk("fwd_a_wb", a_fwd_a, 2'b10);
    ex_rs1 = 5'd0;
    #1;
    chk("fwd_a_x0", a_fwd_a, 2'b00);
    ex_rs1 = 5'd3; wb_reg_write = 1'b0;
    #1;
    chk("fwd_a_none", a_fwd_a, 2'b00);
    chk("fwd_no_stall", a_if_stall, 1'b0);

    // Load-use: lw x5 in EX, add x6,x5,x1 in ID.
    clr_inputs();
    ex_is_load = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd5;
    id_rs1 = 5'd5; id_use_rs1 = 1'b1; id_rs2 = 5'd1; id_use_rs2 = 1'b1;
    #1;
    chk("lu_if_stall",    a_if_stall, 1'b1);
    chk("lu_if_id_stall", a_if_id_stall, 1'b1);
    chk("lu_id_ex_flush", a_id_ex_flush, 1'b1);
    chk("lu_if_id_flush", a_if_id_flush, 1'b0);
    tick();
    ex_is_load = 1'b0; ex_reg_write = 1'b0; ex_rd = 5'd0;
    mem_rd = 5'd5; mem_reg_write = 1'b1; mem_is_load = 1'b1;
    #1;
    chk("lu1_valid_after", a_valid, 4'hD);
    chk("lu1_memload_no_stall", a_if_stall, 1'b0);
    chk("lu2_memload_stall", b_if_stall, 1'b1);
    chk("lu2_memload_flush", b_id_ex_flush, 1'b1);
    tick();
    mem_rd = 5'd0; mem_reg_write = 1'b0; mem_is_load = 1'b0;
    wb_rd = 5'd5; wb_reg_write = 1'b1; ex_rs1 = 5'd5; id_use_rs1 = 1'b0;
    #1;
    chk("lu1_valid_use", a_valid, 4'hB);
    chk("lu1_fwd_wb", a_fwd_a, 2'b10);
    chk("lu2_valid_use", b_valid, 4'h9);
    chk("lu2_fwd_bubble", b_fwd_a, 2'b00);

    // Asynchronous reset in the middle of a load-use stall.
    reset_fill();
    ex_is_load = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd7;
    id_rs2 = 5'd7; id_use_rs2 = 1'b1;
    #1;
    chk("mid_stall_active", a_if_stall, 1'b1);
    rstn = 1'b0;
    #1;
    chk("mid_rst_valid", a_valid, 4'h0);
    chk("mid_rst_if_stall", a_if_stall, 1'b0);
    chk("mid_rst_if_id_stall", a_if_id_stall, 1'b0);
    chk("mid_rst_id_ex_flush", a_id_ex_flush, 1'b0);

    // Redirect with imem not ready for 3 cycles.
    reset_fill();
    ex_redirect = 1'b1; i_imem_ready = 1'b0;
    #1;
    chk("rd_c1_if_id_flush", a_if_id_flush, 1'b1);
    chk("rd_c1_id_ex_flush", a_id_ex_flush, 1'b1);
    chk("rd_c1_if_stall", a_if_stall, 1'b0);
    tick();
    ex_redirect = 1'b0;
    #1;
    chk("rd_c2_valid", a_valid, 4'hC);
    chk("rd_c2_if_id_flush", a_if_id_flush, 1'b1);
    chk("rd_c2_if_stall", a_if_stall, 1'b1);
    tick();
    #1;
    chk("rd_c3_valid", a_valid, 4'h8);
    chk("rd_c3_if_id_flush", a_if_id_flush, 1'b1);
    tick();
    i_imem_ready = 1'b1;
    #1;
    chk("rd_c4_valid", a_valid, 4'h0);
    chk("rd_c4_if_id_flush", a_if_id_flush, 1'b1);
    chk("rd_c4_if_stall", a_if_stall, 1'b0);
    tick();
    #1;
    chk("rd_run_if_id_flush", a_if_id_flush, 1'b0);
    chk("rd_run_valid", a_valid, 4'h0);
`ifdef PIPE_CTRL_PERF_EN
    chk("rd_perf_flush", a_flush_cnt, 32'd1);
    chk("rd_perf_stall", a_stall_cyc, 32'd2);
    chk("rd_perf_retired", a_retired, 32'd3);
`else
    chk("rd_perf_flush", a_flush_cnt, 32'd0);
    chk("rd_perf_stall", a_stall_cyc, 32'd0);
    chk("rd_perf_retired", a_retired, 32'd0);
`endif

    // Data memory wait of 4 cycles with a redirect pending in EX.
    reset_fill();
    i_dmem_req = 1'b1; i_dmem_ready = 1'b0; ex_redirect = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("dm_valid", a_valid, (k == 0) ? 4'hF : 4'h7);
      chk("dm_ex_mem_stall", a_ex_mem_stall, 1'b1);
      chk("dm_mem_wb_flush", a_mem_wb_flush, 1'b1);
      chk("dm_id_ex_flush", a_id_ex_flush, 1'b0);
      chk("dm_if_stall", a_if_stall, 1'b1);
      tick();
    end
    i_dmem_ready = 1'b1;
    #1;
    chk("dm_c5_if_id_flush", a_if_id_flush, 1'b1);
    chk("dm_c5_id_ex_flush", a_id_ex_flush, 1'b1);
    chk("dm_c5_ex_mem_stall", a_ex_mem_stall, 1'b0);
    chk("dm_c5_mem_wb_flush", a_mem_wb_flush, 1'b0);
    tick();
    i_dmem_req = 1'b0; ex_redirect = 1'b0;
    #1;
    chk("dm_after_valid", a_valid, 4'hC);
`ifdef PIPE_CTRL_PERF_EN
    chk("dm_perf_stall", a_stall_cyc, 32'd4);
    chk("dm_perf_flush", a_flush_cnt, 32'd1);
    chk("dm_perf_retired", a_retired, 32'd1);
`else
    chk("dm_perf_stall", a_stall_cyc, 32'd0);
    chk("dm_perf_flush", a_flush_cnt, 32'd0);
    chk("dm_perf_retired", a_retired, 32'd0);
`endif

    // Plain instruction fetch wait in RUN.
    i_imem_ready = 1'b0;
    #1;
    chk("iw_if_stall", a_if_stall, 1'b1);
    chk("iw_if_id_flush", a_if_id_flush, 1'b1);
    chk("iw_id_ex_flush", a_id_ex_flush, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
